vliw_fetch_unit: RTL and testbench

//   Instruction fetch stage of the VLIW core. Drives the PC into main_memory's fetch port and captures
//   the 128-bit, 4-slot bundle it returns combinationally. Buffers bundles in a small queue and

---
 rtl/vliw_pkg.sv | 11 +
 rtl/vliw_fetch_unit_bundle_fifo.sv | 72 +++++++
 rtl/vliw_fetch_unit.sv | 78 +++++++
 tb/tb_vliw_fetch_unit.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/vliw_pkg.sv
// Shared widths and the fetch queue entry type for the VLIW front end.
package vliw_pkg;
    localparam int BUNDLE_W     = 128;
    localparam int INST_W       = 32;
    localparam int BUNDLE_BYTES = 16;

    typedef struct packed {
        logic [31:0]          pc;
        logic [BUNDLE_W-1:0]  bundle;
    } fetch_entry_t;
endpackage

// File: rtl/vliw_fetch_unit_bundle_fifo.sv
// Sync FIFO of fetch entries with flush; head is read combinationally from storage.
// Latency: a pushed entry is visible at the head one cycle later.
// Backpressure: full blocks push unless a pop happens in the same cycle; flush beats push.
module bundle_fifo
    import vliw_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  fetch_entry_t               push_dat_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output fetch_entry_t               head_dat_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t    mem_q [DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_push, do_pop;

    assign full_o     = (count_q == CW'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign head_dat_o = mem_q[head_q];

    assign do_pop  = pop_i & !empty_o;
    assign do_push = push_i & (!full_o | do_pop);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_pop)  head_d = head_q + PW'(1);
            if (do_push) tail_d = tail_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: nothing reads it while count is zero.
    always_ff @(posedge clk) begin
        if (!rst && !flush_i && do_push) mem_q[tail_q] <= push_dat_i;
    end
endmodule

// File: rtl/vliw_fetch_unit.sv
// VLIW fetch stage: drives the PC to memory, queues returned bundles, handles redirect and data-region halt.
// Latency: bundle fetched in cycle N reaches the head in cycle N+1; one bundle per cycle in steady state.
// Backpressure: fetch stalls while the queue is full and decode is not popping.
module vliw_fetch_unit
    import vliw_pkg::*;
#(
    parameter int          QUEUE_DEPTH = 4,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [31:0]          pc_out,
    input  logic [BUNDLE_W-1:0]  inst_bundle_in,
    input  logic [31:0]          data_start_addr,
    input  logic                 redirect_valid,
    input  logic [31:0]          redirect_pc,
    output logic                 bundle_valid,
    input  logic                 bundle_ready,
    output logic [31:0]          bundle_pc,
    output logic [BUNDLE_W-1:0]  bundle_data,
    output logic                 fetch_halted
);
    logic [31:0]                  fetch_pc_q, fetch_pc_d;
    logic                         halted_q, halted_d;
    logic                         halt_cond, push, pop;
    fetch_entry_t                 push_entry, head_entry;
    logic [$clog2(QUEUE_DEPTH):0] fifo_count;
    logic                         fifo_full, fifo_empty;
    logic                         unused_sigs;

    assign unused_sigs = ^{redirect_pc[3:0], fifo_count};

    assign halt_cond  = (data_start_addr != 32'h0) && (fetch_pc_q >= data_start_addr);
    assign pop        = bundle_valid & bundle_ready;
    assign push       = !redirect_valid & !halted_q & !halt_cond & (!fifo_full | pop);
    assign push_entry = '{pc: fetch_pc_q, bundle: inst_bundle_in};

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        halted_d   = halted_q;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[31:4], 4'h0};
            halted_d   = 1'b0;
        end else begin
            if (halt_cond) halted_d = 1'b1;
            if (push)      fetch_pc_d = fetch_pc_q + 32'(BUNDLE_BYTES);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            halted_q   <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            halted_q   <= halted_d;
        end
    end

    bundle_fifo #(.DEPTH(QUEUE_DEPTH)) u_bundle_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .push_dat_i (push_entry),
        .pop_i      (pop),
        .flush_i    (redirect_valid),
        .head_dat_o (head_entry),
        .count_o    (fifo_count),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    assign pc_out       = fetch_pc_q;
    assign bundle_valid = !fifo_empty;
    assign bundle_pc    = head_entry.pc;
    assign bundle_data  = head_entry.bundle;
    assign fetch_halted = halted_q;
endmodule

// File: tb/tb_vliw_fetch_unit.sv
// Directed bench for vliw_fetch_unit against a combinational memory model.
module tb_vliw_fetch_unit;
    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  pc_out;
    logic [127:0] inst_bundle_in;
    logic [31:0]  data_start_addr;
    logic         redirect_valid;
    logic [31:0]  redirect_pc;
    logic         bundle_valid;
    logic         bundle_ready;
    logic [31:0]  bundle_pc;
    logic [127:0] bundle_data;
    logic         fetch_halted;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] idx);
        return 32'hC0DE_0000 ^ idx;
    endfunction

    function automatic logic [127:0] mem_bundle(input logic [31:0] pc);
        logic [31:0] w;
        w = pc >> 2;
        return {mem_word(w), mem_word(w + 1), mem_word(w + 2), mem_word(w + 3)};
    endfunction

    assign inst_bundle_in = mem_bundle(pc_out);

    vliw_fetch_unit #(.QUEUE_DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk             (clk),
        .rst             (rst),
        .pc_out          (pc_out),
        .inst_bundle_in  (inst_bundle_in),
        .data_start_addr (data_start_addr),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .bundle_valid    (bundle_valid),
        .bundle_ready    (bundle_ready),
        .bundle_pc       (bundle_pc),
        .bundle_data     (bundle_data),
        .fetch_halted    (fetch_halted)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic ready);
        rst             = 1'b1;
        bundle_ready    = ready;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst             = 1'b1;
        data_start_addr = 32'h0;

        // 1: reset state and streaming
        do_reset(1'b1);
        chk("rst_pc", 128'(pc_out), 128'h0);
        chk("rst_valid", 128'(bundle_valid), 128'h0);
        chk("rst_halted", 128'(fetch_halted), 128'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t1_valid", 128'(bundle_valid), 128'h1);
            chk("t1_bpc", 128'(bundle_pc), 128'(32'(16 * k)));
            chk("t1_data", bundle_data, mem_bundle(32'(16 * k)));
            chk("t1_pcout", 128'(pc_out), 128'(32'(16 * k + 16)));
        end

        // 2: backpressure fills queue, then drain in order
        do_reset(1'b0);
        repeat (10) step();
        chk("t2_pc_hold", 128'(pc_out), 128'h40);
        chk("t2_head", 128'(bundle_pc), 128'h0);
        bundle_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("t2_drain", 128'(bundle_pc), 128'(32'(16 * k)));
            step();
        end

        // 3: halt at data region and drain
        data_start_addr = 32'h30;
        do_reset(1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t3_bpc", 128'(bundle_pc), 128'(32'(16 * k)));
        end
        step();
        chk("t3_valid", 128'(bundle_valid), 128'h0);
        chk("t3_halted", 128'(fetch_halted), 128'h1);
        chk("t3_pc", 128'(pc_out), 128'h30);
        repeat (3) step();
        chk("t3_hold_pc", 128'(pc_out), 128'h30);
        chk("t3_hold_valid", 128'(bundle_valid), 128'h0);

        // 5: redirect out of halt
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        step();
        redirect_valid = 1'b0;
        chk("t5_halted", 128'(fetch_halted), 128'h0);
        chk("t5_pc", 128'(pc_out), 128'h0);
        chk("t5_valid", 128'(bundle_valid), 128'h0);
        step();
        chk("t5_bpc", 128'(bundle_pc), 128'h0);
        chk("t5_valid2", 128'(bundle_valid), 128'h1);

        // redirect into data region: halts, nothing pushed
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        step();
        redirect_valid = 1'b0;
        chk("tr_halted0", 128'(fetch_halted), 128'h0);
        step();
        chk("tr_halted1", 128'(fetch_halted), 128'h1);
        chk("tr_valid", 128'(bundle_valid), 128'h0);
        chk("tr_pc", 128'(pc_out), 128'h200);
        data_start_addr = 32'h0;

        // 4: redirect with pop while queue holds 0x10..0x40
        do_reset(1'b0);
        repeat (4) step();
        bundle_ready = 1'b1;
        step();
        chk("t4_head", 128'(bundle_pc), 128'h10);
        chk("t4_pc", 128'(pc_out), 128'h50);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h104;
        step();
        redirect_valid = 1'b0;
        chk("t4_flush_valid", 128'(bundle_valid), 128'h0);
        chk("t4_flush_pc", 128'(pc_out), 128'h100);
        step();
        chk("t4_bpc0", 128'(bundle_pc), 128'h100);
        chk("t4_data0", bundle_data, mem_bundle(32'h100));
        step();
        chk("t4_bpc1", 128'(bundle_pc), 128'h110);

        // PC wraps modulo 2^32
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF7;
        step();
        redirect_valid = 1'b0;
        chk("wrap_start", 128'(pc_out), 128'hFFFF_FFF0);
        step();
        chk("wrap_pc", 128'(pc_out), 128'h0);
        chk("wrap_bpc", 128'(bundle_pc), 128'hFFFF_FFF0);

        // 6: reset mid-operation discards entries
        do_reset(1'b0);
        repeat (3) step();
        chk("t6_pre_valid", 128'(bundle_valid), 128'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_valid", 128'(bundle_valid), 128'h0);
        chk("t6_pc", 128'(pc_out), 128'h0);
        chk("t6_halted", 128'(fetch_halted), 128'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
